// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, chip-enable levels and the
// all-zero doubleword the ROM returns while disabled.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  localparam logic        CHIP_ENABLE      = 1'b1;
  localparam logic        CHIP_DISABLE     = 1'b0;
  localparam logic [63:0] ZERO_DOUBLE_WORD = 64'h0;

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// Program counter register: a redirect load beats a sequential increment, otherwise it holds.
// Async active-low reset returns the counter to RESET_PC.
module inst_fetch_pc_reg #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + ADDR_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, drives the ROM and registers instructions into IF/ID.
// Optional accepted-fetch counter is built when FETCH_PERF_EN is defined.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  input  logic              br_flag_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              halt_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              align_err_o,
  output logic [31:0]       fetch_cnt_o
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              capture;
  logic              misaligned;

  // A redirect or halt on the same edge always wins over a capture.
  assign capture    = (state == ST_FETCH) && !br_flag_i && !halt_i &&
                      (!id_valid_o || id_ready_i);
  assign misaligned = |(br_target_i & ADDR_W'(PC_STEP - 1));
  assign rom_addr_o = pc;

  inst_fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (br_flag_i),
    .load_addr (br_target_i),
    .inc       (capture),
    .pc        (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rom_ce_o    <= CHIP_DISABLE;
      id_valid_o  <= 1'b0;
      id_pc_o     <= '0;
      id_inst_o   <= INST_W'(ZERO_DOUBLE_WORD);
      align_err_o <= 1'b0;
    end else if (br_flag_i) begin
      // Any redirect flushes IF/ID; a misaligned target parks the fetcher in HALT.
      id_valid_o <= 1'b0;
      if (misaligned) begin
        align_err_o <= 1'b1;
        state       <= ST_HALT;
        rom_ce_o    <= CHIP_DISABLE;
      end else begin
        state    <= ST_FETCH;
        rom_ce_o <= CHIP_ENABLE;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_FETCH;
          rom_ce_o <= CHIP_ENABLE;
        end
        ST_FETCH: begin
          if (halt_i) begin
            state    <= ST_HALT;
            rom_ce_o <= CHIP_DISABLE;
            if (id_valid_o && id_ready_i) begin
              id_valid_o <= 1'b0;
            end
          end else if (capture) begin
            id_valid_o <= 1'b1;
            id_pc_o    <= pc;
            id_inst_o  <= rom_inst_i;
          end
        end
        ST_HALT: begin
          rom_ce_o <= CHIP_DISABLE;
          if (id_valid_o && id_ready_i) begin
            id_valid_o <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          rom_ce_o <= CHIP_DISABLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
    end else if (capture) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt;
`else
  assign fetch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a ROM model answers fetches, accepted IF/ID
// transfers are popped from an expectation queue by a separate monitor.
module tb_inst_fetch;

  localparam int ADDR_W = 32;
  localparam int INST_W = 64;

`ifdef FETCH_PERF_EN
  localparam logic [31:0] EXP_CNT = 32'd8;
`else
  localparam logic [31:0] EXP_CNT = 32'd0;
`endif

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;
  logic              br_flag;
  logic [ADDR_W-1:0] br_target;
  logic              halt;
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              align_err;
  logic [31:0]       fetch_cnt;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  inst_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_ce_o    (rom_ce),
    .rom_addr_o  (rom_addr),
    .rom_inst_i  (rom_inst),
    .br_flag_i   (br_flag),
    .br_target_i (br_target),
    .halt_i      (halt),
    .id_valid_o  (id_valid),
    .id_ready_i  (id_ready),
    .id_pc_o     (id_pc),
    .id_inst_o   (id_inst),
    .align_err_o (align_err),
    .fetch_cnt_o (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word tags its own address so a wrong-address capture is visible.
  function automatic logic [INST_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return {16'hC0DE, a[19:4], a};
  endfunction

  assign rom_inst = rom_ce ? rom_word(rom_addr) : 64'h0;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = rom_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic br, input logic [ADDR_W-1:0] tgt,
                                input logic hlt, input logic rdy);
    br_flag   = br;
    br_target = tgt;
    halt      = hlt;
    id_ready  = rdy;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_valid"}, 64'(id_valid), 64'd0);
    check_output({tag, "_ce"}, 64'(rom_ce), 64'd0);
    check_output({tag, "_addr"}, 64'(rom_addr), 64'd0);
    check_output({tag, "_id_pc"}, 64'(id_pc), 64'd0);
    check_output({tag, "_id_inst"}, id_inst, 64'd0);
    check_output({tag, "_align"}, 64'(align_err), 64'd0);
    check_output({tag, "_cnt"}, 64'(fetch_cnt), 64'd0);
  endtask

  // Monitor: every cycle the decode side accepts, the next expectation must match.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("[TB] FAIL unexpected_accept: got pc 0x%0h, expected none", id_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("accept_pc", 64'(id_pc), 64'(e.pc));
          check_output("accept_inst", id_inst, e.inst);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    #3;
    check_reset_values("reset");

    @(posedge clk);
    #2;
    rst_n = 1'b1;
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    push_exp(32'h00);
    push_exp(32'h10);
    push_exp(32'h20);

    step(1);
    check_output("first_edge_ce", 64'(rom_ce), 64'd1);
    check_output("first_edge_addr", 64'(rom_addr), 64'h0);
    check_output("first_edge_valid", 64'(id_valid), 64'd0);
    step(1);
    check_output("first_valid", 64'(id_valid), 64'd1);
    check_output("first_id_pc", 64'(id_pc), 64'h0);
    check_output("seq_addr_10", 64'(rom_addr), 64'h10);
    step(2);
    check_output("seq_id_pc_20", 64'(id_pc), 64'h20);
    check_output("seq_addr_30", 64'(rom_addr), 64'h30);

    // Backpressure: IF/ID and PC must freeze.
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_output("stall_id_pc", 64'(id_pc), 64'h20);
      check_output("stall_id_inst", id_inst, rom_word(32'h20));
      check_output("stall_addr", 64'(rom_addr), 64'h30);
      check_output("stall_valid", 64'(id_valid), 64'd1);
    end
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    step(1);
    check_output("release_id_pc", 64'(id_pc), 64'h30);
    check_output("release_addr", 64'(rom_addr), 64'h40);

    // Redirect while 0x30 is still unaccepted: it must be flushed.
    apply_stimulus(1'b1, 32'h70, 1'b0, 1'b0);
    step(1);
    check_output("redir_flush_valid", 64'(id_valid), 64'd0);
    check_output("redir_addr", 64'(rom_addr), 64'h70);
    push_exp(32'h70);
    push_exp(32'h80);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    step(1);
    check_output("redir_id_pc", 64'(id_pc), 64'h70);
    check_output("redir_valid", 64'(id_valid), 64'd1);
    step(1);
    check_output("redir_next_id_pc", 64'(id_pc), 64'h80);

    // Halt: 0x80 is accepted on the halt edge, then nothing is fetched.
    apply_stimulus(1'b0, '0, 1'b1, 1'b1);
    step(1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    check_output("halt_ce", 64'(rom_ce), 64'd0);
    check_output("halt_addr", 64'(rom_addr), 64'h90);
    check_output("halt_valid", 64'(id_valid), 64'd0);
    step(2);
    check_output("halt_hold_addr", 64'(rom_addr), 64'h90);
    check_output("halt_hold_valid", 64'(id_valid), 64'd0);
    check_output("halt_hold_ce", 64'(rom_ce), 64'd0);

    push_exp(32'h10);
    apply_stimulus(1'b1, 32'h10, 1'b0, 1'b1);
    step(1);
    check_output("resume_ce", 64'(rom_ce), 64'd1);
    check_output("resume_addr", 64'(rom_addr), 64'h10);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    step(1);
    check_output("resume_id_pc", 64'(id_pc), 64'h10);
    step(1);
    check_output("resume_id_pc2", 64'(id_pc), 64'h20);
    check_output("fetch_cnt", 64'(fetch_cnt), 64'(EXP_CNT));
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);

    // Misaligned redirect: sticky error, fetch disabled until an aligned redirect.
    apply_stimulus(1'b1, 32'h48, 1'b0, 1'b0);
    step(1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    check_output("align_err_set", 64'(align_err), 64'd1);
    check_output("align_ce", 64'(rom_ce), 64'd0);
    check_output("align_valid", 64'(id_valid), 64'd0);
    check_output("align_addr", 64'(rom_addr), 64'h48);
    step(1);
    check_output("align_hold_ce", 64'(rom_ce), 64'd0);
    push_exp(32'h00);
    apply_stimulus(1'b1, 32'h00, 1'b0, 1'b0);
    step(1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    check_output("align_resume_ce", 64'(rom_ce), 64'd1);
    check_output("align_sticky", 64'(align_err), 64'd1);
    step(1);
    check_output("align_resume_id_pc", 64'(id_pc), 64'h0);
    step(1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    check_output("align_resume_id_pc2", 64'(id_pc), 64'h10);

    // Asynchronous reset mid-run.
    rst_n = 1'b0;
    #1;
    check_reset_values("midrun_reset");
    step(1);

    check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch initiator for the 64-bit core: owns the program counter, drives chip-enable and address into the combinational instruction ROM, and registers the returned instruction into the IF/ID stage with a valid/ready handshake. It sits between the ROM and the decode stage and handles sequential fetch, backpressure, branch redirect with flush, and halt.

## Interface
- ADDR_W, 32, instruction address width (matches `InstAddrBus`)
- INST_W, 64, instruction width (matches `InstBus`)
- RESET_PC, 0, PC loaded at reset
- PC_STEP, 16, byte stride between sequential instructions; ROM indexes from addr bit 4
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rom_ce_o  out  1  ROM chip enable (`ChipEnable`/`ChipDisable`)
- rom_addr_o  out  ADDR_W  ROM address, equals current PC
- rom_inst_i  in  INST_W  ROM data, combinational from rom_addr_o
- br_flag_i  in  1  redirect request from execute
- br_target_i  in  ADDR_W  redirect target
- halt_i  in  1  stop fetching
- id_valid_o  out  1  IF/ID holds a valid instruction
- id_ready_i  in  1  decode accepts this cycle
- id_pc_o  out  ADDR_W  PC of registered instruction
- id_inst_o  out  INST_W  registered instruction
- align_err_o  out  1  sticky: redirect target not PC_STEP-aligned
- fetch_cnt_o  out  32  accepted-fetch counter (see Configuration)

## Operation
- States: IDLE, FETCH, HALT.
- IDLE: entered on reset; rom_ce_o=0; next edge -> FETCH.
- FETCH: rom_ce_o=1. Capture condition = !id_valid_o || id_ready_i. On capture: id_inst_o<=rom_inst_i, id_pc_o<=pc, id_valid_o<=1, pc<=pc+PC_STEP (wraps modulo 2^ADDR_W). No capture: pc and IF/ID registers hold.
- Priority each edge: redirect > halt > capture/hold.
- Redirect (br_flag_i=1, any state): pc<=br_target_i, id_valid_o<=0 (wrong-path instruction flushed, even if unaccepted), state->FETCH. If br_target_i[3:0]!=0: align_err_o<=1, state->HALT, pc still loaded.
- halt_i=1 in FETCH (no redirect): state->HALT, no capture; id_valid_o cleared only when id_ready_i accepts it.
- HALT: rom_ce_o=0; pc frozen; leaves only via a redirect with aligned target. align_err_o clears only on reset.
- rom_ce_o=0 implies ROM returns `ZeroDoubleWord`; never captured.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, rom_ce_o=0, rom_addr_o=RESET_PC, id_valid_o=0, id_pc_o=0, id_inst_o=0, align_err_o=0, fetch_cnt_o=0.
- First instruction visible on id_* two edges after reset deassert.
- Fetch latency: one edge from rom_addr_o to id_inst_o. Throughput one instruction/cycle with id_ready_i=1.
- Redirect: target on rom_addr_o the cycle after br_flag_i; first target instruction valid one edge later (one bubble).
- Backpressure: id_* stable while id_valid_o && !id_ready_i.

## Configuration
- FETCH_PERF_EN defined: fetch_cnt_o increments (wrapping at 2^32) on every capture edge; cleared by reset only.
- Undefined: counter logic absent, fetch_cnt_o tied to 0.

## Structure
- State encodings, RESET_PC default, `ChipEnable`/`ChipDisable`, `ZeroDoubleWord` live in the shared defines.v.
- One sub-module: pc_reg (PC register with load/increment/hold, async reset to RESET_PC).

## Test plan
- Reset then id_ready_i=1 -> rom_addr_o 0x0,0x10,0x20,…; id_pc_o/id_inst_o follow one edge later; first valid 2 edges after reset.
- Hold id_ready_i=0 for 3 cycles at id_pc_o=0x20 -> id_* stable, rom_addr_o=0x30 stable; release -> 0x30 captured next edge.
- br_flag_i with br_target_i=0x70 while id_valid_o=1, id_ready_i=0 -> id_valid_o=0 next edge, rom_addr_o=0x70, id_pc_o=0x70 one edge later.
- br_target_i=0x48 -> align_err_o=1 sticky, rom_ce_o=0; later redirect to 0x00 resumes fetch, align_err_o stays 1.
- halt_i pulse -> rom_ce_o=0, pc frozen, no captures; redirect to 0x10 resumes.
- FETCH_PERF_EN: 8 accepted fetches -> fetch_cnt_o=8; rst_n low mid-run -> all outputs at reset values immediately.
